// File: rtl/spi_pkg.sv
// Shared SPI shifter types and defaults.
// Also used by the APB register block.
package spi_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_shifter.sv
// SPI master serialiser: shifts a TX word out on mosi
// and assembles an RX word from miso on the selected sclk strobe.
module spi_shifter
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  P_clk,
  input  logic                  P_rst,
  input  logic                  ss,
  input  logic                  send_data,
  input  logic                  lsbfe,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  flag_low,
  input  logic                  flag_high,
  input  logic [DATA_WIDTH-1:0] data_mosi,
  input  logic                  miso,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] data_miso,
  output logic                  receive_data,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int DW = DATA_WIDTH;

  state_t          state, state_n;
  logic [DW-1:0]   tx_shift, tx_n;
  logic [DW-1:0]   rx_shift, rx_n;
  logic [CW-1:0]   bit_cnt, cnt_n;
  logic            lsb_q, lsb_n;
  logic            mosi_n;
  logic [DW-1:0]   dm_n;
  logic            rd_n;
  logic            busy_n;
  logic            edge_s;
  logic            last;

  assign edge_s = (cpol ^ cpha) ? flag_high : flag_low;
  assign last   = (bit_cnt == CW'(DW - 1));

  always_ff @(posedge P_clk) begin
    if (P_rst) begin
      state        <= IDLE;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      lsb_q        <= 1'b0;
      mosi         <= 1'b0;
      data_miso    <= '0;
      receive_data <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      tx_shift     <= tx_n;
      rx_shift     <= rx_n;
      bit_cnt      <= cnt_n;
      lsb_q        <= lsb_n;
      mosi         <= mosi_n;
      data_miso    <= dm_n;
      receive_data <= rd_n;
      busy         <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    tx_n    = tx_shift;
    rx_n    = rx_shift;
    cnt_n   = bit_cnt;
    lsb_n   = lsb_q;
    mosi_n  = mosi;
    dm_n    = data_miso;
    rd_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (send_data) begin
          tx_n    = data_mosi;
          lsb_n   = lsbfe;
          cnt_n   = '0;
          mosi_n  = lsbfe ? data_mosi[0]
                          : data_mosi[DW-1];
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (!ss) state_n = SHIFT;
      end
      SHIFT: begin
        // Abort wins over a coincident strobe.
        if (ss) begin
          state_n = IDLE;
        end else if (edge_s) begin
          if (lsb_q) begin
            rx_n = {miso, rx_shift[DW-1:1]};
            tx_n = {1'b0, tx_shift[DW-1:1]};
          end else begin
            rx_n = {rx_shift[DW-2:0], miso};
            tx_n = {tx_shift[DW-2:0], 1'b0};
          end
          cnt_n = bit_cnt + CW'(1);
          if (last) begin
            dm_n    = rx_n;
            rd_n    = 1'b1;
            state_n = DONE;
          end else begin
            mosi_n = lsb_q ? tx_shift[1]
                           : tx_shift[DW-2];
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_spi_shifter.sv
// Directed and randomized bench for spi_shifter
// against a bit-order reference model.
module tb_spi_shifter;
  import spi_pkg::*;

  localparam int DW = 8;

  logic          P_clk = 1'b0;
  logic          P_rst = 1'b1;
  logic          ss = 1'b1;
  logic          send_data = 1'b0;
  logic          lsbfe = 1'b0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          flag_low = 1'b0;
  logic          flag_high = 1'b0;
  logic [DW-1:0] data_mosi = '0;
  logic          miso = 1'b0;
  logic          mosi;
  logic [DW-1:0] data_miso;
  logic          receive_data;
  logic          busy;

  int tests = 0;
  int fails = 0;

  spi_shifter #(.DATA_WIDTH(DW)) dut (
    .P_clk(P_clk),
    .P_rst(P_rst),
    .ss(ss),
    .send_data(send_data),
    .lsbfe(lsbfe),
    .cpol(cpol),
    .cpha(cpha),
    .flag_low(flag_low),
    .flag_high(flag_high),
    .data_mosi(data_mosi),
    .miso(miso),
    .mosi(mosi),
    .data_miso(data_miso),
    .receive_data(receive_data),
    .busy(busy)
  );

  always #5 P_clk = ~P_clk;

  // i-th bit on the wire for a given word and order
  function automatic logic bitat(
    input logic [DW-1:0] w,
    input int i,
    input bit lsb
  );
    return lsb ? w[i] : w[DW-1-i];
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge P_clk);
    #1;
  endtask

  task automatic strobe(input logic b, input bit hi);
    miso = b;
    if (hi) flag_high = 1'b1;
    else flag_low = 1'b1;
    cyc(1);
    flag_high = 1'b0;
    flag_low = 1'b0;
  endtask

  task automatic start(
    input logic [DW-1:0] w,
    input bit lsb,
    input bit pol,
    input bit pha
  );
    cpol = pol;
    cpha = pha;
    lsbfe = lsb;
    data_mosi = w;
    send_data = 1'b1;
    cyc(1);
    send_data = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_mosi", 32'(mosi), 32'(bitat(w, 0, lsb)));
  endtask

  task automatic shift_word(
    input logic [DW-1:0] w,
    input logic [DW-1:0] m,
    input bit lsb,
    input bit hi,
    input int gap,
    input bit inject
  );
    ss = 1'b0;
    cyc(1);
    for (int i = 0; i < DW; i++) begin
      chk($sformatf("mosi%0d", i), 32'(mosi),
          32'(bitat(w, i, lsb)));
      strobe(bitat(m, i, lsb), hi);
      if (i < DW - 1) begin
        chk("no_rd", 32'(receive_data), 32'd0);
        for (int g = 0; g < gap - 1; g++) begin
          if (inject && i == 3 && g == 0) begin
            data_mosi = '1;
            send_data = 1'b1;
          end
          cyc(1);
          send_data = 1'b0;
        end
      end
    end
    chk("rd_pulse", 32'(receive_data), 32'd1);
    chk("rx_word", 32'(data_miso), 32'(m));
    chk("done_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("rd_end", 32'(receive_data), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("mosi_hold", 32'(mosi),
        32'(bitat(w, DW - 1, lsb)));
  endtask

  initial begin
    logic [DW-1:0] w, m;
    bit lsb, pol, pha;

    cyc(2);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_dm", 32'(data_miso), 32'd0);
    chk("rst_rd", 32'(receive_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    P_rst = 1'b0;
    cyc(1);

    ss = 1'b0;
    start(8'hA5, 1'b0, 1'b0, 1'b0);
    shift_word(8'hA5, 8'h3C, 1'b0, 1'b0, 16, 1'b0);

    // abort with a coincident strobe
    start(8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1, 1'b0);
      cyc(2);
    end
    ss = 1'b1;
    strobe(1'b1, 1'b0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd", 32'(receive_data), 32'd0);
    chk("abort_dm", 32'(data_miso), 32'h3C);
    chk("abort_mosi", 32'(mosi), 32'd0);
    cyc(3);
    chk("abort_rd2", 32'(receive_data), 32'd0);

    // wrong strobe ignored, then send_data injected
    ss = 1'b0;
    start(8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1, 1'b1);
      cyc(1);
    end
    chk("wrong_cnt", 32'(dut.bit_cnt), 32'd0);
    chk("wrong_mosi", 32'(mosi), 32'd1);
    shift_word(8'hA5, 8'hC3, 1'b0, 1'b0, 4, 1'b1);

    ss = 1'b1;
    start(8'h81, 1'b1, 1'b0, 1'b1);
    shift_word(8'h81, 8'h5A, 1'b1, 1'b1, 16, 1'b0);

    // armed hold with ss high
    ss = 1'b1;
    start(8'h96, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      flag_high = 1'b1;
      flag_low = 1'b1;
      cyc(1);
      flag_high = 1'b0;
      flag_low = 1'b0;
      cyc(1);
    end
    chk("armed_state", 32'(dut.state), 32'(ARMED));
    chk("armed_mosi", 32'(mosi), 32'd1);
    shift_word(8'h96, 8'h71, 1'b0, 1'b0, 3, 1'b0);

    // reset mid-transfer
    ss = 1'b0;
    start(8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      strobe(1'b1, 1'b0);
      cyc(1);
    end
    P_rst = 1'b1;
    cyc(1);
    P_rst = 1'b0;
    chk("mrst_mosi", 32'(mosi), 32'd0);
    chk("mrst_dm", 32'(data_miso), 32'd0);
    chk("mrst_rd", 32'(receive_data), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_state", 32'(dut.state), 32'(IDLE));
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1, 1'b0);
      chk("mrst_nord", 32'(receive_data), 32'd0);
    end

    for (int k = 0; k < 8; k++) begin
      w = DW'($urandom);
      m = DW'($urandom);
      lsb = 1'($urandom_range(0, 1));
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      ss = 1'($urandom_range(0, 1));
      start(w, lsb, pol, pha);
      shift_word(w, m, lsb, pol ^ pha,
                 int'($urandom_range(1, 8)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_shifter.md
Name: spi_shifter

Overview:
- Serialising data path of the APB SPI master core.
- Consumes the one-P_clk-wide edge strobes from the baud-rate generator (flag_low / flag_high).
- Shifts a parallel TX word out on mosi and samples miso into an RX word.
- Sits between the APB register block (data_mosi, send_data, control bits) and the pins; returns data_miso / receive_data to the register block.

Parameters:
DATA_WIDTH, 8, transfer word length in bits (>=2)

Ports:
P_clk  input  1  system clock
P_rst  input  1  reset; synchronous, active-high
ss  input  1  slave select, active-low; 0 = transfer enabled
send_data  input  1  one-cycle request: load data_mosi and start
lsbfe  input  1  1 = LSB first, 0 = MSB first; sampled at load
cpol  input  1  clock polarity
cpha  input  1  clock phase
flag_low  input  1  strobe: sclk leaves low this cycle
flag_high  input  1  strobe: sclk leaves high this cycle
data_mosi  input  DATA_WIDTH  word to transmit
miso  input  1  serial input from slave
mosi  output  1  serial output to slave
data_miso  output  DATA_WIDTH  last completed received word
receive_data  output  1  one-cycle pulse: data_miso updated
busy  output  1  1 while state != IDLE

Behaviour:
- Strobe select: edge = (cpol ^ cpha) ? flag_high : flag_low. The non-selected flag is ignored.
- All outputs registered. Reset (P_rst=1 at a P_clk edge) has priority over everything:
  - state=IDLE, mosi=0, data_miso=0, receive_data=0, busy=0
  - internal tx/rx shift registers and bit_cnt cleared
- FSM states: IDLE, ARMED, SHIFT, DONE.
- IDLE:
  - send_data=1 -> tx_shift<=data_mosi, lsb_q<=lsbfe, bit_cnt<=0.
  - mosi <= lsbfe ? data_mosi[0] : data_mosi[DATA_WIDTH-1], i.e. first bit driven before the first edge.
  - Go to ARMED.
- ARMED:
  - ss=0 -> SHIFT. Strobes arriving in ARMED are ignored.
  - ss=1 -> stay in ARMED.
- SHIFT, on edge=1 with ss=0:
  - rx_shift takes miso: MSB-first shifts left and inserts at bit 0; LSB-first shifts right and inserts at bit DATA_WIDTH-1.
  - tx_shift advances the same direction and mosi <= next tx bit.
  - bit_cnt++.
- SHIFT, last bit (bit_cnt==DATA_WIDTH-1 on an edge):
  - data_miso <= complete rx word including this bit; receive_data<=1.
  - mosi holds its value; go to DONE.
- DONE: lasts exactly one cycle (receive_data=1, busy=1), then IDLE with receive_data<=0.
- Latency: last edge in cycle N -> data_miso/receive_data valid in N+1 -> busy=0 in N+2.
- Abort: ss=1 in SHIFT -> IDLE next edge, with priority over a simultaneous strobe.
  - No receive_data; data_miso keeps its previous value; mosi holds.
- send_data in ARMED/SHIFT/DONE is ignored; no queueing.
- lsbfe/cpol/cpha changes mid-transfer: direction is fixed by lsb_q. The strobe select follows live cpol/cpha; the register block must not change them while busy.
- mosi retains the last driven bit in IDLE until the next load.
- bit_cnt width = $clog2(DATA_WIDTH); it never wraps because the FSM exits at DATA_WIDTH-1.

Decomposition:
- Shared package spi_pkg: state encodings (IDLE=2'd0, ARMED=2'd1, SHIFT=2'd2, DONE=2'd3) and the DATA_WIDTH default, shared with the register block.
- No sub-module; edge selection is a single mux inside the block.

Test Plan:
- cpol=0,cpha=0, lsbfe=0, data_mosi=8'hA5, ss=0, 8 flag_low strobes 16 cycles apart, miso driving 8'h3C MSB-first:
  - mosi = 1,0,1,0,0,1,0,1.
  - data_miso=8'h3C with a single receive_data pulse one cycle after the 8th strobe.
  - busy low one cycle later.
- cpol=0,cpha=1, lsbfe=1, data_mosi=8'h81, 8 flag_high strobes, miso driving 8'h5A LSB-first:
  - mosi = 1,0,0,0,0,0,0,1; data_miso=8'h5A.
- Wrong strobe: cpol=cpha=0, pulse flag_high 4 times in SHIFT -> no shift, bit_cnt stays 0, mosi unchanged.
- Abort: after 3 strobes raise ss=1 coincident with a 4th strobe -> IDLE next cycle, busy=0, no receive_data, data_miso still 8'h3C.
- send_data pulsed with data_mosi=8'hFF during SHIFT -> ignored; the original 8'hA5 bit stream completes.
- ARMED hold: send_data with ss=1, strobes toggling -> stays in ARMED, no shifting; ss=0 then resumes normal transfer.
- P_rst=1 mid-transfer at bit 5 -> next edge: all outputs at reset values, state IDLE; no receive_data ever asserts for that word.
